// File: rtl/id_issue_if.sv
// Bundle of fetch, register-file, execute and writeback signals around the decode/issue stage.
interface id_issue_if;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic        ex_valid;
  logic        ex_ready;
  logic [10:0] ex_alu_op;
  logic [31:0] ex_alu_src1;
  logic [31:0] ex_alu_src2;
  logic [4:0]  ex_rd;
  logic        ex_rf_we;
  logic        ex_mem_re;
  logic        ex_mem_we;
  logic [31:0] ex_store_data;
  logic [31:0] ex_pc;
  logic        ex_illegal;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;

  modport slave (
    input  if_valid, if_inst, if_pc, rf_rdata1, rf_rdata2, ex_ready, wb_valid, wb_rd, flush,
    output if_ready, rf_raddr1, rf_raddr2, ex_valid, ex_alu_op, ex_alu_src1, ex_alu_src2,
           ex_rd, ex_rf_we, ex_mem_re, ex_mem_we, ex_store_data, ex_pc, ex_illegal
  );

  modport master (
    output if_valid, if_inst, if_pc, rf_rdata1, rf_rdata2, ex_ready, wb_valid, wb_rd, flush,
    input  if_ready, rf_raddr1, rf_raddr2, ex_valid, ex_alu_op, ex_alu_src1, ex_alu_src2,
           ex_rd, ex_rf_we, ex_mem_re, ex_mem_we, ex_store_data, ex_pc, ex_illegal
  );
endinterface

// File: rtl/id_issue_stage.sv
// RV32I decode/issue stage: decodes one instruction per cycle into a registered ALU request,
// stalling on RAW/WAW hazards tracked by a writeback-cleared busy-bit scoreboard.
module id_issue_stage #(
  parameter int unsigned XLEN         = 32,
  parameter logic [31:0] RESET_PC_TAG = 32'h0
) (
  input logic       clk,
  input logic       rst,
  id_issue_if.slave bus
);

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;
  localparam logic [6:0] OpcLoad  = 7'b0000011;
  localparam logic [6:0] OpcStore = 7'b0100011;

  localparam logic [10:0] AluAdd  = 11'h001;
  localparam logic [10:0] AluSub  = 11'h002;
  localparam logic [10:0] AluSlt  = 11'h004;
  localparam logic [10:0] AluSltu = 11'h008;
  localparam logic [10:0] AluAnd  = 11'h010;
  localparam logic [10:0] AluOr   = 11'h020;
  localparam logic [10:0] AluXor  = 11'h040;
  localparam logic [10:0] AluSll  = 11'h080;
  localparam logic [10:0] AluSrl  = 11'h100;
  localparam logic [10:0] AluSra  = 11'h200;
  localparam logic [10:0] AluLui  = 11'h400;

  logic [31:0] inst;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  assign inst   = bus.if_inst;
  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];

  assign bus.rf_raddr1 = rs1;
  assign bus.rf_raddr2 = rs2;

  logic [XLEN-1:0] rs1_val, rs2_val, imm_i, imm_s, imm_u, shamt;
  assign rs1_val = (rs1 == 5'd0) ? '0 : bus.rf_rdata1;
  assign rs2_val = (rs2 == 5'd0) ? '0 : bus.rf_rdata2;
  assign imm_i   = {{20{inst[31]}}, inst[31:20]};
  assign imm_s   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_u   = {inst[31:12], 12'b0};
  assign shamt   = {27'b0, inst[24:20]};

  logic [10:0]     op_d;
  logic [XLEN-1:0] src1_d, src2_d, store_data_d;
  logic            rf_we_raw, rf_we_d, mem_re_d, mem_we_d, illegal_d, use1, use2;

  always_comb begin
    op_d         = AluAdd;
    src1_d       = '0;
    src2_d       = '0;
    store_data_d = '0;
    rf_we_raw    = 1'b0;
    mem_re_d     = 1'b0;
    mem_we_d     = 1'b0;
    illegal_d    = 1'b0;
    use1         = 1'b0;
    use2         = 1'b0;
    case (opcode)
      OpcOp: begin
        use1 = 1'b1; use2 = 1'b1; rf_we_raw = 1'b1;
        src1_d = rs1_val; src2_d = rs2_val;
        case ({funct7, funct3})
          {7'b0000000, 3'b000}: op_d = AluAdd;
          {7'b0100000, 3'b000}: op_d = AluSub;
          {7'b0000000, 3'b001}: op_d = AluSll;
          {7'b0000000, 3'b010}: op_d = AluSlt;
          {7'b0000000, 3'b011}: op_d = AluSltu;
          {7'b0000000, 3'b100}: op_d = AluXor;
          {7'b0000000, 3'b101}: op_d = AluSrl;
          {7'b0100000, 3'b101}: op_d = AluSra;
          {7'b0000000, 3'b110}: op_d = AluOr;
          {7'b0000000, 3'b111}: op_d = AluAnd;
          default:              illegal_d = 1'b1;
        endcase
      end
      OpcOpImm: begin
        use1 = 1'b1; rf_we_raw = 1'b1;
        src1_d = rs1_val; src2_d = imm_i;
        case (funct3)
          3'b000: op_d = AluAdd;
          3'b010: op_d = AluSlt;
          3'b011: op_d = AluSltu;
          3'b100: op_d = AluXor;
          3'b110: op_d = AluOr;
          3'b111: op_d = AluAnd;
          3'b001: begin
            op_d = AluSll; src2_d = shamt;
            illegal_d = (funct7 != 7'b0000000);
          end
          default: begin
            src2_d = shamt;
            if (funct7 == 7'b0000000)      op_d = AluSrl;
            else if (funct7 == 7'b0100000) op_d = AluSra;
            else                           illegal_d = 1'b1;
          end
        endcase
      end
      OpcLui: begin
        op_d = AluLui; src2_d = imm_u; rf_we_raw = 1'b1;
      end
      OpcAuipc: begin
        src1_d = bus.if_pc; src2_d = imm_u; rf_we_raw = 1'b1;
      end
      OpcLoad: begin
        use1 = 1'b1; src1_d = rs1_val; src2_d = imm_i; mem_re_d = 1'b1; rf_we_raw = 1'b1;
        illegal_d = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OpcStore: begin
        use1 = 1'b1; use2 = 1'b1; src1_d = rs1_val; src2_d = imm_s; mem_we_d = 1'b1;
        store_data_d = rs2_val;
        illegal_d = (funct3 > 3'b010);
      end
      default: illegal_d = 1'b1;
    endcase
    // Illegal encodings still issue, but as an inert add that touches no state.
    if (illegal_d) begin
      op_d = AluAdd; src1_d = '0; src2_d = '0; store_data_d = '0;
      rf_we_raw = 1'b0; mem_re_d = 1'b0; mem_we_d = 1'b0; use1 = 1'b0; use2 = 1'b0;
    end
  end

  assign rf_we_d = rf_we_raw & (rd != 5'd0);

  logic [31:0]     busy_q, busy_d;
  logic            ex_valid_q, ex_rf_we_q, ex_mem_re_q, ex_mem_we_q, ex_illegal_q;
  logic [10:0]     ex_alu_op_q;
  logic [XLEN-1:0] ex_src1_q, ex_src2_q, ex_store_data_q, ex_pc_q;
  logic [4:0]      ex_rd_q;
  logic            hazard, issue;

  assign hazard = bus.if_valid & ((busy_q[rs1] & use1) | (busy_q[rs2] & use2) |
                                  (busy_q[rd] & rf_we_d));
  assign bus.if_ready = ~bus.flush & ~hazard & (~ex_valid_q | bus.ex_ready);
  assign issue = bus.if_valid & bus.if_ready;

  // Later updates override earlier ones, so a same-cycle set beats a clear.
  always_comb begin
    busy_d = busy_q;
    if (bus.wb_valid && bus.wb_rd != 5'd0) busy_d[bus.wb_rd] = 1'b0;
    if (bus.flush && ex_valid_q && ex_rf_we_q) busy_d[ex_rd_q] = 1'b0;
    if (issue && rf_we_d) busy_d[rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q          <= '0;
      ex_valid_q      <= 1'b0;
      ex_alu_op_q     <= '0;
      ex_src1_q       <= '0;
      ex_src2_q       <= '0;
      ex_rd_q         <= '0;
      ex_rf_we_q      <= 1'b0;
      ex_mem_re_q     <= 1'b0;
      ex_mem_we_q     <= 1'b0;
      ex_store_data_q <= '0;
      ex_pc_q         <= RESET_PC_TAG;
      ex_illegal_q    <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (bus.flush) begin
        ex_valid_q <= 1'b0;
      end else if (issue) begin
        ex_valid_q      <= 1'b1;
        ex_alu_op_q     <= op_d;
        ex_src1_q       <= src1_d;
        ex_src2_q       <= src2_d;
        ex_rd_q         <= rd;
        ex_rf_we_q      <= rf_we_d;
        ex_mem_re_q     <= mem_re_d;
        ex_mem_we_q     <= mem_we_d;
        ex_store_data_q <= store_data_d;
        ex_pc_q         <= bus.if_pc;
        ex_illegal_q    <= illegal_d;
      end else if (bus.ex_ready) begin
        ex_valid_q <= 1'b0;
      end
    end
  end

  assign bus.ex_valid      = ex_valid_q;
  assign bus.ex_alu_op     = ex_alu_op_q;
  assign bus.ex_alu_src1   = ex_src1_q;
  assign bus.ex_alu_src2   = ex_src2_q;
  assign bus.ex_rd         = ex_rd_q;
  assign bus.ex_rf_we      = ex_rf_we_q;
  assign bus.ex_mem_re     = ex_mem_re_q;
  assign bus.ex_mem_we     = ex_mem_we_q;
  assign bus.ex_store_data = ex_store_data_q;
  assign bus.ex_pc         = ex_pc_q;
  assign bus.ex_illegal    = ex_illegal_q;

endmodule

// File: tb/tb_id_issue_stage.sv
// Directed bench for id_issue_stage: decode, x0 handling, hazards, backpressure, flush, reset.
module tb_id_issue_stage;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  id_issue_if bus ();

  id_issue_stage #(
    .XLEN        (32),
    .RESET_PC_TAG(32'h0000_1000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addi_x0(input logic [4:0] rdn, input logic [11:0] imm);
    return {imm, 5'd0, 3'b000, rdn, 7'b0010011};
  endfunction

  initial begin
    rst = 1'b1;
    bus.if_valid = 1'b0; bus.if_inst = '0; bus.if_pc = '0;
    bus.rf_rdata1 = '0; bus.rf_rdata2 = '0; bus.ex_ready = 1'b1;
    bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", bus.ex_valid, 0);
    check("rst_op", bus.ex_alu_op, 0);
    check("rst_src", bus.ex_alu_src1 | bus.ex_alu_src2, 0);
    check("rst_we", {bus.ex_rf_we, bus.ex_mem_re, bus.ex_mem_we, bus.ex_illegal}, 0);
    check("rst_pc", bus.ex_pc, 32'h0000_1000);
    rst = 1'b0;

    // add x0,x1,x2
    bus.if_valid = 1'b1; bus.if_inst = 32'h0020_8033; bus.if_pc = 32'h100;
    bus.rf_rdata1 = 32'd5; bus.rf_rdata2 = 32'd7;
    #1;
    check("raddr1", bus.rf_raddr1, 1);
    check("raddr2", bus.rf_raddr2, 2);
    check("add_ready", bus.if_ready, 1);
    tick();
    check("add_valid", bus.ex_valid, 1);
    check("add_op", bus.ex_alu_op, 11'h001);
    check("add_src1", bus.ex_alu_src1, 5);
    check("add_src2", bus.ex_alu_src2, 7);
    check("add_rd0_we", bus.ex_rf_we, 0);
    check("add_pc", bus.ex_pc, 32'h100);

    // srai x5,x1,3
    bus.if_inst = 32'h4030_D293; bus.rf_rdata1 = 32'h8000_0000;
    tick();
    check("srai_op", bus.ex_alu_op, 11'h200);
    check("srai_src1", bus.ex_alu_src1, 32'h8000_0000);
    check("srai_src2", bus.ex_alu_src2, 3);
    check("srai_rd", bus.ex_rd, 5);
    check("srai_we", bus.ex_rf_we, 1);

    // add x6,x5,x0 must wait for x5 writeback
    bus.if_inst = 32'h0002_8333; bus.rf_rdata1 = 32'h11; bus.rf_rdata2 = 32'h22;
    #1;
    check("raw_stall0", bus.if_ready, 0);
    tick();
    check("drained", bus.ex_valid, 0);
    check("raw_stall1", bus.if_ready, 0);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd5;
    #1;
    check("no_bypass", bus.if_ready, 0);
    tick();
    bus.wb_valid = 1'b0;
    #1;
    check("raw_release", bus.if_ready, 1);
    tick();
    check("add6_valid", bus.ex_valid, 1);
    check("add6_rd", bus.ex_rd, 6);
    check("add6_src1", bus.ex_alu_src1, 32'h11);
    check("x0_forced", bus.ex_alu_src2, 0);

    // lui x5 / auipc x5
    bus.if_inst = 32'h1234_52B7; bus.if_pc = 32'h8000_0000;
    tick();
    check("lui_op", bus.ex_alu_op, 11'h400);
    check("lui_src1", bus.ex_alu_src1, 0);
    check("lui_src2", bus.ex_alu_src2, 32'h1234_5000);
    bus.if_valid = 1'b0; bus.wb_valid = 1'b1; bus.wb_rd = 5'd5;
    tick();
    bus.wb_valid = 1'b0;
    bus.if_valid = 1'b1; bus.if_inst = 32'h1234_5297;
    #1;
    check("auipc_ready", bus.if_ready, 1);
    tick();
    check("auipc_op", bus.ex_alu_op, 11'h001);
    check("auipc_src1", bus.ex_alu_src1, 32'h8000_0000);
    check("auipc_src2", bus.ex_alu_src2, 32'h1234_5000);

    // Backpressure then back-to-back issue
    bus.if_valid = 1'b0;
    tick();
    bus.ex_ready = 1'b0; bus.if_valid = 1'b1; bus.if_inst = addi_x0(5'd8, 12'd8);
    tick();
    check("bp_valid", bus.ex_valid, 1);
    bus.if_inst = addi_x0(5'd9, 12'd9);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready", bus.if_ready, 0);
      tick();
      check("bp_hold_rd", bus.ex_rd, 8);
      check("bp_hold_src2", bus.ex_alu_src2, 8);
      check("bp_hold_valid", bus.ex_valid, 1);
    end
    bus.ex_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.if_inst = addi_x0(5'(9 + k), 12'(9 + k));
      #1;
      check("b2b_ready", bus.if_ready, 1);
      tick();
      check("b2b_rd", bus.ex_rd, 9 + k);
      check("b2b_src2", bus.ex_alu_src2, 9 + k);
    end

    // addi x13,x0,-1 : sign-extended immediate
    bus.if_inst = 32'hFFF0_0693;
    tick();
    check("imm_sext", bus.ex_alu_src2, 32'hFFFF_FFFF);

    // sw x2,8(x1)
    bus.if_inst = 32'h0020_A423; bus.rf_rdata1 = 32'h100; bus.rf_rdata2 = 32'hDEAD_BEEF;
    tick();
    check("sw_op", bus.ex_alu_op, 11'h001);
    check("sw_src1", bus.ex_alu_src1, 32'h100);
    check("sw_src2", bus.ex_alu_src2, 8);
    check("sw_flags", {bus.ex_mem_we, bus.ex_mem_re, bus.ex_rf_we}, 3'b100);
    check("sw_data", bus.ex_store_data, 32'hDEAD_BEEF);

    // lw x3,4(x1)
    bus.if_inst = 32'h0040_A183;
    tick();
    check("lw_flags", {bus.ex_mem_we, bus.ex_mem_re, bus.ex_rf_we}, 3'b011);
    check("lw_src2", bus.ex_alu_src2, 4);
    check("lw_rd", bus.ex_rd, 3);

    // Unsupported opcode and slli with a bad funct7
    bus.if_inst = 32'h0000_007F;
    tick();
    check("ill_flag", bus.ex_illegal, 1);
    check("ill_we", bus.ex_rf_we, 0);
    check("ill_op", bus.ex_alu_op, 11'h001);
    check("ill_src1", bus.ex_alu_src1, 0);
    bus.if_inst = 32'h4000_9093;
    tick();
    check("slli_f7_ill", bus.ex_illegal, 1);
    check("slli_f7_we", bus.ex_rf_we, 0);

    // addi x7,x0,1 then flush while held
    bus.if_inst = 32'h0010_0393;
    tick();
    check("fl_valid", bus.ex_valid, 1);
    check("fl_rd", bus.ex_rd, 7);
    bus.ex_ready = 1'b0; bus.flush = 1'b1; bus.if_inst = 32'h0020_0393;
    #1;
    check("fl_block", bus.if_ready, 0);
    tick();
    bus.flush = 1'b0;
    check("fl_killed", bus.ex_valid, 0);
    #1;
    check("fl_busy7_clr", bus.if_ready, 1);
    tick();
    check("fl_next_src2", bus.ex_alu_src2, 2);
    check("fl_next_valid", bus.ex_valid, 1);

    // add x15,x7,x0 stalls on x7; reset lands between edges
    bus.if_inst = 32'h0003_87B3;
    #1;
    check("rs_stall", bus.if_ready, 0);
    #2;
    rst = 1'b1;
    #1;
    check("rs_valid", bus.ex_valid, 0);
    check("rs_rd", bus.ex_rd, 0);
    check("rs_src2", bus.ex_alu_src2, 0);
    check("rs_pc", bus.ex_pc, 32'h0000_1000);
    tick();
    rst = 1'b0;
    bus.ex_ready = 1'b1;
    #1;
    check("rs_busy_clr", bus.if_ready, 1);
    tick();
    check("rs_issue_rd", bus.ex_rd, 15);
    check("rs_issue_valid", bus.ex_valid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
